parity_frame_rx: RTL and testbench

Serial receiver and checker for the 7-bit parity link. The link transmitter sends seven data bits followed by the parity generator's P bit, where P = XOR of x[6:0]. This block sits at the far end of the link. It deserialises one frame, recomputes parity over the received bits, and presents the 7-bit word with parity and framing status. It also keeps a saturating count of bad frames.

---
 rtl/parity_link_pkg.sv | 21 ++
 rtl/parity7_calc.sv | 11 +
 rtl/parity_frame_rx.sv | 149 ++++++++++++++
 tb/tb_parity_frame_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/parity_link_pkg.sv
// Shared definitions for the 7-bit parity link: frame geometry, receiver
// state encoding and the parity function used by generator and checker.
package parity_link_pkg;

  localparam int DATA_BITS  = 7;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Even parity: P makes the total number of ones across d[6:0] and P even.
  function automatic logic parity7(input logic [DATA_BITS-1:0] x);
    return ^x;
  endfunction

endpackage

// File: rtl/parity7_calc.sv
// Combinational 7-input XOR shared by the link's parity generator and checker.
module parity7_calc
  import parity_link_pkg::*;
(
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 parity_o
);

  assign parity_o = parity7(data_i);

endmodule

// File: rtl/parity_frame_rx.sv
// Far-end receiver for the 7-bit parity link: deserialises start, d[6:0], P,
// stop; reports parity/framing status and a saturating bad-frame count.
module parity_frame_rx
  import parity_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic [6:0]           data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     samp_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [6:0]           shift_q;
  logic                 p_rx_q;
  logic                 stop_q;
  logic                 stop_done_q;
  logic                 armed_q;
  logic [6:0]           data_out_q;
  logic                 data_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic calc_par;
  logic parity_err_d;
  logic frame_err_d;

  // Two-flop synchroniser; idles high so reset does not fake a start bit.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_serial};
  end
  assign rx_s = sync_q[1];

  parity7_calc u_parity (
    .data_i   (shift_q),
    .parity_o (calc_par)
  );

  assign parity_err_d = (calc_par != p_rx_q);
  assign frame_err_d  = !stop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_rx_q       <= 1'b0;
      stop_q       <= 1'b1;
      stop_done_q  <= 1'b0;
      armed_q      <= 1'b1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          samp_cnt_q  <= '0;
          bit_cnt_q   <= '0;
          stop_done_q <= 1'b0;
          // After a framing error the line must return high before a new start.
          if (rx_s)         armed_q <= 1'b1;
          else if (armed_q) state_q <= START;
        end
        START: begin
          if (samp_cnt_q == HALF_M1) begin
            samp_cnt_q <= '0;
            state_q    <= rx_s ? IDLE : DATA;
          end else begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (samp_cnt_q == FULL_M1) begin
            samp_cnt_q <= '0;
            shift_q    <= {shift_q[5:0], rx_s};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (samp_cnt_q == FULL_M1) begin
            samp_cnt_q <= '0;
            p_rx_q     <= rx_s;
            state_q    <= STOP;
          end else begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (stop_done_q) begin
            data_out_q   <= shift_q;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            data_valid_q <= 1'b1;
            if ((parity_err_d || frame_err_d) && (err_count_q != ERR_MAX))
              err_count_q <= err_count_q + ERR_CNT_W'(1);
            armed_q     <= stop_q;
            stop_done_q <= 1'b0;
            state_q     <= IDLE;
          end else if (samp_cnt_q == FULL_M1) begin
            samp_cnt_q  <= '0;
            stop_q      <= rx_s;
            stop_done_q <= 1'b1;
          end else begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: directed frames feed an expected queue that a
// negedge monitor pops on every data_valid pulse.
module tb_parity_frame_rx;

  localparam int CPB     = 16;
  localparam int LATENCY = 155;
  localparam int EW      = 49;

  logic       clk;
  logic       reset;
  logic       rx_serial;
  logic [6:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] err_count;
  logic       busy;

  // {expected rise cycle[31:0], err_count[7:0], frame_err, parity_err, data[6:0]}
  logic [EW-1:0] exp_q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int dv_count = 0;
  logic dv_prev = 1'b0;
  logic [7:0] model_cnt = 8'd0;

  parity_frame_rx #(.CLKS_PER_BIT(CPB), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    tick(CPB);
  endtask

  // Sends one full frame; the expected result is queued before the start bit.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic stop,
                            input logic exp_perr, input logic exp_ferr);
    logic [31:0] exp_cyc;
    if ((exp_perr || exp_ferr) && model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
    exp_cyc = 32'(cyc + 1 + LATENCY);
    exp_q.push_back({exp_cyc, model_cnt, exp_ferr, exp_perr, d});
    drive_bit(1'b0);
    for (int i = 6; i >= 0; i--) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
    rx_serial = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (data_valid) begin
      dv_count++;
      check("dv_not_consecutive", 64'(dv_prev), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_dv", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("dv_cycle",   64'(cyc),        64'(e[48:17]));
        check("err_count",  64'(err_count),  64'(e[16:9]));
        check("frame_err",  64'(frame_err),  64'(e[8]));
        check("parity_err", 64'(parity_err), 64'(e[7]));
        check("data_out",   64'(data_out),   64'(e[6:0]));
      end
    end
    dv_prev <= data_valid;
  end

  initial begin : stim
    int dv_before;
    logic saw_busy;
    logic [6:0] d;
    reset = 1'b1;
    rx_serial = 1'b1;
    tick(5);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_dv", 64'(data_valid), 64'd0);
    check("rst_perr", 64'(parity_err), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    check("rst_cnt", 64'(err_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick(20);

    // good frame, bad parity, framing error
    send_frame(7'b1010011, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(400);
    send_frame(7'b0000111, 1'b0, 1'b1, 1'b1, 1'b0);
    drain(400);
    send_frame(7'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
    drain(400);
    tick(20);

    // start-bit glitch: 4 clocks low
    dv_before = dv_count;
    saw_busy = 1'b0;
    rx_serial = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (busy) saw_busy = 1'b1;
    end
    rx_serial = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (busy) saw_busy = 1'b1;
    end
    check("glitch_busy_seen", 64'(saw_busy), 64'd1);
    tick(20);
    check("glitch_busy_low", 64'(busy), 64'd0);
    check("glitch_no_dv", 64'(dv_count), 64'(dv_before));
    check("glitch_data", 64'(data_out), 64'h7F);
    check("glitch_perr", 64'(parity_err), 64'd0);
    check("glitch_ferr", 64'(frame_err), 64'd1);
    check("glitch_cnt", 64'(err_count), 64'd2);

    // reset during the 4th data bit
    d = 7'h55;
    drive_bit(1'b0);
    for (int i = 6; i >= 4; i--) drive_bit(d[i]);
    rx_serial = d[3];
    tick(8);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_cnt = 8'd0;
    check("mid_rst_data_out", 64'(data_out), 64'd0);
    check("mid_rst_dv", 64'(data_valid), 64'd0);
    check("mid_rst_perr", 64'(parity_err), 64'd0);
    check("mid_rst_ferr", 64'(frame_err), 64'd0);
    check("mid_rst_cnt", 64'(err_count), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    rx_serial = 1'b1;
    tick(40);
    dv_before = dv_count;
    send_frame(7'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(400);
    check("post_rst_one_dv", 64'(dv_count - dv_before), 64'd1);
    tick(10);

    // 300 back-to-back bad-parity frames; count saturates at 0xFF
    dv_before = dv_count;
    for (int i = 0; i < 300; i++) begin
      d = 7'(i);
      send_frame(d, ~(^d), 1'b1, 1'b1, 1'b0);
    end
    drain(400);
    check("b2b_dv_count", 64'(dv_count - dv_before), 64'd300);
    check("b2b_cnt_sat", 64'(err_count), 64'hFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
